ai_cu_ifm_reader: RTL

Input-feature-map read engine for the AI control unit. It services the control FSM's fetch-phase read request (base address plus word count), issues pipelined single-word reads on the memory bus, buffers returned words in a credit-protected FIFO, and streams them to the compute datapath over a valid/ready port. It pulses `mem_read_done` back to the FSM once the consumer has taken the final word.

---
 rtl/ai_cu_ifm_reader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ai_cu_ifm_reader.sv
// IFM read engine: fetch request -> pipelined single-word bus reads -> credit-protected FIFO -> valid/ready stream.
// Optional feature macro AI_IFM_READER_STATS_EN adds stall_cnt (consumer backpressure cycles per transfer).

// Generic synchronous FIFO with registered storage; head word drives rd_dat directly.
// Latency: word written at edge M is visible on rd_vld/rd_dat right after edge M.
// Backpressure: no wr_rdy; the writer guarantees space, push+pop together is legal at any fill level.
module ai_cu_ifm_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;
    assign push   = wr_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Input-feature-map reader: issues base+i*bytes reads, buffers returns, streams them, pulses done.
// Latency: request -> bus_req next cycle; rvalid -> ifm_valid next cycle; last pop -> done next cycle.
// Backpressure: bus_req only while outstanding + fifo fill < depth, so every return has a free slot.
module ai_cu_ifm_reader #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_req,
    input  logic [ADDR_W-1:0] mem_read_addr,
    input  logic [LEN_W-1:0]  mem_read_len,
    output logic              mem_read_done,
    output logic              busy,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              ifm_valid,
    output logic [DATA_W-1:0] ifm_data,
    input  logic              ifm_ready
`ifdef AI_IFM_READER_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  iss_cnt;
    logic [LEN_W-1:0]  pop_cnt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_sum;
    logic              credit_ok;
    logic              start;
    logic              xfer_active;
    logic              addr_fire;
    logic              push_vld;
    logic              pop_fire;
    logic              last_issue;
    logic              last_pop;

    assign start       = (state == IDLE) && mem_read_req;
    assign xfer_active = (state == ISSUE) || (state == DRAIN);
    assign credit_sum  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok   = credit_sum < (CW+1)'(FIFO_DEPTH);
    assign addr_fire   = bus_req && bus_gnt;
    // Returns with nothing outstanding (stray or past the length) never reach the FIFO.
    assign push_vld    = bus_rvalid && xfer_active && (outstanding != '0);
    assign pop_fire    = ifm_valid && ifm_ready;
    assign last_issue  = addr_fire && (iss_cnt == len_r - LEN_W'(1));
    assign last_pop    = (pop_cnt == len_r) ||
                         (pop_fire && (pop_cnt == len_r - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_read_req) state_nxt = (mem_read_len == '0) ? DONE : ISSUE;
            ISSUE:   if (last_issue)   state_nxt = DRAIN;
            DRAIN:   if (last_pop)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        bus_req       = 1'b0;
        bus_addr      = '0;
        mem_read_done = 1'b0;
        case (state)
            ISSUE: begin
                busy     = 1'b1;
                bus_req  = credit_ok;
                bus_addr = base_r + ADDR_W'(iss_cnt) * BYTES;
            end
            DRAIN:   busy = 1'b1;
            DONE: begin
                busy          = 1'b1;
                mem_read_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r      <= '0;
            len_r       <= '0;
            iss_cnt     <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
        end else if (start) begin
            base_r      <= mem_read_addr;
            len_r       <= mem_read_len;
            iss_cnt     <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
        end else begin
            if (addr_fire)               iss_cnt <= iss_cnt + LEN_W'(1);
            if (pop_fire && xfer_active) pop_cnt <= pop_cnt + LEN_W'(1);
            case ({addr_fire, push_vld})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    ai_cu_ifm_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_dat (bus_rdata),
        .rd_vld (ifm_valid),
        .rd_dat (ifm_data),
        .rd_rdy (ifm_ready),
        .count  (fifo_count)
    );

`ifdef AI_IFM_READER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (start) begin
            stall_cnt <= '0;
        end else if (xfer_active && ifm_valid && !ifm_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
